pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PC_WIDTH, 16, program counter width.
- OFFSET_WIDTH, 9, signed branch offset width.
- STACK_DEPTH, 8, return-address stack entries (power of two, >=2).
- RESET_VECTOR, 0, PC value after reset.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clock, in, 1, rising-edge clock.
- Reset, in, 1, synchronous, active-high.
- Stall, in, 1, hold all state this cycle.
- LoadEnable, in, 1, absolute jump to LoadValue.
- LoadValue, in, PC_WIDTH, jump/call target.
- OffsetEnable, in, 1, relative branch by Offset.
- Offset, in, OFFSET_WIDTH, two's-complement branch offset.
- CallEnable, in, 1, push return address and jump to LoadValue.
- ReturnEnable, in, 1, pop return address into PC.
- CounterValue, out, PC_WIDTH, current PC (registered).
- StackCount, out, $clog2(STACK_DEPTH)+1, stack occupancy.
- StackOverflow, out, 1, sticky: call attempted while full.
- StackUnderflow, out, 1, sticky: return attempted while empty.

Function
REQ-003 CounterValue SHALL be a register updated only on the rising Clock edge; no output is combinationally dependent on inputs.
REQ-004 Per-cycle priority SHALL be Reset > Stall > ReturnEnable > CallEnable > LoadEnable > OffsetEnable > increment.
REQ-005 Stall=1 SHALL hold CounterValue, stack contents, StackCount and flags unchanged.
REQ-006 Increment SHALL set PC to PC+1 modulo 2^PC_WIDTH (0xFFFF -> 0x0000 at default width).
REQ-007 Offset branch SHALL set PC to PC + sign-extended Offset, modulo 2^PC_WIDTH (e.g. PC=0x0002, Offset=-4 -> 0xFFFE).
REQ-008 Load SHALL set PC to LoadValue.
REQ-009 Call SHALL push PC+1 (modulo 2^PC_WIDTH) onto the stack, increment StackCount, and set PC to LoadValue in the same cycle.
REQ-010 Return with StackCount>0 SHALL set PC to the top entry and decrement StackCount in the same cycle.
REQ-011 Call with StackCount=STACK_DEPTH SHALL still jump to LoadValue, SHALL discard the push, SHALL leave the stack unchanged, and SHALL set StackOverflow.
REQ-012 Return with StackCount=0 SHALL perform a plain increment and SHALL set StackUnderflow.
REQ-013 Simultaneous CallEnable and ReturnEnable SHALL act as a return only; the call SHALL be ignored.
REQ-014 StackOverflow and StackUnderflow SHALL stay at 1 until Reset.
REQ-015 The push/pop result SHALL be visible on StackCount one cycle after the enabling edge, the same cycle the new CounterValue appears.

Reset
REQ-016 When Reset=1 at a rising edge, the block SHALL set CounterValue=RESET_VECTOR, StackCount=0, StackOverflow=0, StackUnderflow=0, regardless of all other inputs including Stall.
REQ-017 Reset mid-call-chain SHALL discard all stack entries; stack RAM contents need not be cleared.

Structure
REQ-018 Package pc_seq_pkg SHALL hold the action enum (PC_HOLD, PC_RETURN, PC_CALL, PC_LOAD, PC_OFFSET, PC_INC) and the default parameter constants.
REQ-019 The next-action decode SHALL be one combinational priority encoder producing a pc_seq_pkg action value.
REQ-020 The LIFO SHALL be a sub-module return_stack (parameters WIDTH and DEPTH; ports push, pop, push_data, top_data, count, full, empty) with a synchronous Reset.

Verification
REQ-021 Reset then 3 idle cycles -> CounterValue 0x0000, 0x0001, 0x0002, 0x0003; all flags 0.
REQ-022 PC=0x0010, OffsetEnable=1, Offset=9'h1FC (-4) -> PC=0x000C; then Offset=9'h0FF (+255) -> PC=0x010B.
REQ-023 PC=0x0020, Call to 0x0100 -> PC=0x0100, StackCount=1; two increments then Return -> PC=0x0021, StackCount=0.
REQ-024 9 nested calls at STACK_DEPTH=8 -> 9th call jumps, StackCount stays 8, StackOverflow=1; 8 returns unwind in correct LIFO order; a 9th return -> StackUnderflow=1 and PC increments.
REQ-025 Stall=1 together with CallEnable, LoadEnable and OffsetEnable asserted -> PC, StackCount and flags unchanged; Reset during Stall -> PC=RESET_VECTOR.
REQ-026 PC=0xFFFF increment -> 0x0000; Call at PC=0xFFFF pushes 0x0000; simultaneous Call+Return with StackCount=1 -> return taken and StackCount=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared action encoding, defaults and decode helper for pc_sequencer
//
// Purpose : Holds the per-cycle action enum, the default parameter values
//           and the priority decode used by the sequencer.
// Ports   : none (package)
package pc_seq_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RETURN,
    PC_CALL,
    PC_LOAD,
    PC_OFFSET,
    PC_INC
  } pc_action_t;

  localparam int DEF_PC_WIDTH     = 16;
  localparam int DEF_OFFSET_WIDTH = 9;
  localparam int DEF_STACK_DEPTH  = 8;
  localparam int DEF_RESET_VECTOR = 0;

  // Priority order: Stall > Return > Call > Load > Offset > increment.
  // Reset is not decoded here; it overrides everything in the registers.
  function automatic pc_action_t decode_action(
    input logic stall,
    input logic returnEn,
    input logic callEn,
    input logic loadEn,
    input logic offsetEn
  );
    pc_action_t act;
    if (stall)         act = PC_HOLD;
    else if (returnEn) act = PC_RETURN;
    else if (callEn)   act = PC_CALL;
    else if (loadEn)   act = PC_LOAD;
    else if (offsetEn) act = PC_OFFSET;
    else               act = PC_INC;
    return act;
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// rtl/pc_sequencer_return_stack.sv - LIFO of return addresses for pc_sequencer
//
// Purpose : Fixed-depth return-address stack. The occupancy counter doubles
//           as the write pointer; the top entry is read combinationally from
//           registered storage so the caller can use it in the same cycle.
// Ports   : Clock, Reset (sync, active-high)
//           push/push_data : store push_data (ignored while full)
//           pop            : discard top entry (ignored while empty)
//           top_data       : most recently pushed entry
//           count          : occupancy 0..DEPTH
//           full, empty    : occupancy status
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       top_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrIdx;
  logic [AW-1:0]    topIdx;

  // When full, the low bits wrap to 0 and topIdx wraps to DEPTH-1, which is
  // still the correct top entry because DEPTH is a power of two.
  assign wrIdx    = count[AW-1:0];
  assign topIdx   = wrIdx - AW'(1);
  assign top_data = mem[topIdx];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge Clock) begin
    if (Reset)
      count <= '0;
    else if (push && !full)
      count <= count + (AW+1)'(1);
    else if (pop && !empty)
      count <= count - (AW+1)'(1);
  end

  // Storage is not reset; clearing count is enough to discard all entries.
  always_ff @(posedge Clock) begin
    if (push && !full)
      mem[wrIdx] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with branch, call/return stack and sticky fault flags
//
// Purpose : Registered program counter. Each cycle one action is chosen by a
//           priority decode and applied; calls push PC+1 to return_stack.
// Ports   : Clock, Reset (sync, active-high), Stall
//           LoadEnable/LoadValue, OffsetEnable/Offset, CallEnable, ReturnEnable
//           CounterValue   : current PC
//           StackCount     : return stack occupancy
//           StackOverflow  : sticky, call seen while stack full
//           StackUnderflow : sticky, return seen while stack empty
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int STACK_DEPTH  = DEF_STACK_DEPTH,
  parameter int RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Stall,
  input  logic                         LoadEnable,
  input  logic [PC_WIDTH-1:0]          LoadValue,
  input  logic                         OffsetEnable,
  input  logic [OFFSET_WIDTH-1:0]      Offset,
  input  logic                         CallEnable,
  input  logic                         ReturnEnable,
  output logic [PC_WIDTH-1:0]          CounterValue,
  output logic [$clog2(STACK_DEPTH):0] StackCount,
  output logic                         StackOverflow,
  output logic                         StackUnderflow
);

  pc_action_t          action;
  logic [PC_WIDTH-1:0] pcPlusOne;
  logic [PC_WIDTH-1:0] offsetExt;
  logic [PC_WIDTH-1:0] nextPc;
  logic [PC_WIDTH-1:0] topData;
  logic                stackFull;
  logic                stackEmpty;
  logic                doPush;
  logic                doPop;

  always_comb begin
    action = decode_action(Stall, ReturnEnable, CallEnable, LoadEnable, OffsetEnable);
  end

  assign pcPlusOne = CounterValue + PC_WIDTH'(1);
  assign offsetExt = PC_WIDTH'($signed(Offset));

  // A call into a full stack still jumps but drops the push; a return from
  // an empty stack degrades to a plain increment.
  assign doPush = (action == PC_CALL) && !stackFull;
  assign doPop  = (action == PC_RETURN) && !stackEmpty;

  always_comb begin
    nextPc = CounterValue;
    unique case (action)
      PC_HOLD:   nextPc = CounterValue;
      PC_RETURN: nextPc = stackEmpty ? pcPlusOne : topData;
      PC_CALL:   nextPc = LoadValue;
      PC_LOAD:   nextPc = LoadValue;
      PC_OFFSET: nextPc = CounterValue + offsetExt;
      PC_INC:    nextPc = pcPlusOne;
      default:   nextPc = CounterValue;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      CounterValue   <= PC_WIDTH'(RESET_VECTOR);
      StackOverflow  <= 1'b0;
      StackUnderflow <= 1'b0;
    end else begin
      CounterValue <= nextPc;
      if ((action == PC_CALL) && stackFull)
        StackOverflow <= 1'b1;
      if ((action == PC_RETURN) && stackEmpty)
        StackUnderflow <= 1'b1;
    end
  end

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) uStack (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (doPush),
    .pop       (doPop),
    .push_data (pcPlusOne),
    .top_data  (topData),
    .count     (StackCount),
    .full      (stackFull),
    .empty     (stackEmpty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Stall, LoadEnable, OffsetEnable, CallEnable, ReturnEnable;
  logic [15:0] LoadValue;
  logic [8:0]  Offset;
  logic [15:0] CounterValue;
  logic [3:0]  StackCount;
  logic        StackOverflow, StackUnderflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Stall          (Stall),
    .LoadEnable     (LoadEnable),
    .LoadValue      (LoadValue),
    .OffsetEnable   (OffsetEnable),
    .Offset         (Offset),
    .CallEnable     (CallEnable),
    .ReturnEnable   (ReturnEnable),
    .CounterValue   (CounterValue),
    .StackCount     (StackCount),
    .StackOverflow  (StackOverflow),
    .StackUnderflow (StackUnderflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst, stall, re, ce, le, oe;
    logic [15:0] lv;
    logic [8:0]  off;
    logic [15:0] pc;
    logic [3:0]  cnt;
    logic        ov, un;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: the stack is an ordinary queue.
  int          mPc;
  logic [15:0] mStack[$];
  logic        mOv, mUn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic re, input logic ce,
                       input logic le, input logic oe, input logic [15:0] lv, input logic [8:0] off);
    Reset = rst; Stall = stall; ReturnEnable = re; CallEnable = ce;
    LoadEnable = le; OffsetEnable = oe; LoadValue = lv; Offset = off;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [15:0] pc, input logic [3:0] cnt,
                          input logic ov, input logic un);
    check({tag, ".pc"},  32'(CounterValue),   32'(pc));
    check({tag, ".cnt"}, 32'(StackCount),     32'(cnt));
    check({tag, ".ov"},  32'(StackOverflow),  32'(ov));
    check({tag, ".un"},  32'(StackUnderflow), 32'(un));
  endtask

  task automatic addVec(input logic rst, input logic stall, input logic re, input logic ce,
                        input logic le, input logic oe, input logic [15:0] lv, input logic [8:0] off,
                        input logic [15:0] pc, input logic [3:0] cnt, input logic ov, input logic un);
    vec_t v;
    v.rst = rst; v.stall = stall; v.re = re; v.ce = ce; v.le = le; v.oe = oe;
    v.lv = lv; v.off = off; v.pc = pc; v.cnt = cnt; v.ov = ov; v.un = un;
    vecs.push_back(v);
  endtask

  task automatic modelStep(input logic rst, input logic stall, input logic re, input logic ce,
                           input logic le, input logic oe, input logic [15:0] lv, input logic [8:0] off);
    int o;
    if (rst) begin
      mPc = 0; mStack.delete(); mOv = 0; mUn = 0;
    end else if (stall) begin
      mPc = mPc;
    end else if (re) begin
      if (mStack.size() > 0) mPc = int'(mStack.pop_back());
      else begin mPc = (mPc + 1) % 65536; mUn = 1; end
    end else if (ce) begin
      if (mStack.size() < 8) mStack.push_back(16'((mPc + 1) % 65536));
      else mOv = 1;
      mPc = int'(lv);
    end else if (le) begin
      mPc = int'(lv);
    end else if (oe) begin
      o = off[8] ? int'(off) - 512 : int'(off);
      mPc = (mPc + o + 65536) % 65536;
    end else begin
      mPc = (mPc + 1) % 65536;
    end
  endtask

  initial begin
    logic [15:0] ret [9];
    logic [15:0] pcNow;
    logic r, s, re, ce, le, oe;
    logic [15:0] lv;
    logic [8:0] off;

    drive(1, 0, 0, 0, 0, 0, 16'h0, 9'h0);

    //      rst st re ce le oe  lv        off     pc        cnt ov un
    addVec(1, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0000, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0001, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0002, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0003, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 16'h0010, 9'h000, 16'h0010, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 1, 16'h0000, 9'h1FC, 16'h000C, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 1, 16'h0000, 9'h0FF, 16'h010B, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 16'h0020, 9'h000, 16'h0020, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 16'h0100, 9'h000, 16'h0100, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0101, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0102, 1, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0021, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 16'h0002, 9'h000, 16'h0002, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 1, 16'h0000, 9'h1FC, 16'hFFFE, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'hFFFF, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0000, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 16'hFFFF, 9'h000, 16'hFFFF, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 16'h0300, 9'h000, 16'h0300, 1, 0, 0);
    addVec(0, 1, 0, 1, 1, 1, 16'h0700, 9'h005, 16'h0300, 1, 0, 0);
    addVec(0, 0, 1, 1, 0, 0, 16'h0400, 9'h000, 16'h0000, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 16'h0500, 9'h000, 16'h0500, 1, 0, 0);
    addVec(1, 1, 0, 1, 0, 0, 16'h0600, 9'h000, 16'h0000, 0, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0001, 0, 0, 1);
    addVec(0, 1, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0001, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0002, 0, 0, 1);
    addVec(1, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0000, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].re, vecs[i].ce,
            vecs[i].le, vecs[i].oe, vecs[i].lv, vecs[i].off);
      checkAll($sformatf("vec%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].ov, vecs[i].un);
    end

    // Nested calls past the stack depth, then unwind beyond empty.
    drive(1, 0, 0, 0, 0, 0, 16'h0, 9'h0);
    pcNow = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      ret[i] = pcNow + 16'd1;
      pcNow = 16'h1000 + 16'(i * 16);
      drive(0, 0, 0, 1, 0, 0, pcNow, 9'h0);
      checkAll($sformatf("nest%0d", i), pcNow, (i < 8) ? 4'(i + 1) : 4'd8, i == 8, 1'b0);
    end
    for (int i = 7; i >= 0; i--) begin
      drive(0, 0, 1, 0, 0, 0, 16'h0, 9'h0);
      checkAll($sformatf("unwind%0d", i), ret[i], 4'(i), 1'b1, 1'b0);
    end
    drive(0, 0, 1, 0, 0, 0, 16'h0, 9'h0);
    checkAll("unwind_empty", ret[0] + 16'd1, 4'd0, 1'b1, 1'b1);

    // Randomized traffic against the queue-based model.
    drive(1, 0, 0, 0, 0, 0, 16'h0, 9'h0);
    modelStep(1, 0, 0, 0, 0, 0, 16'h0, 9'h0);
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 7) == 0);
      re  = ($urandom_range(0, 3) == 0);
      ce  = ($urandom_range(0, 2) == 0);
      le  = ($urandom_range(0, 7) == 0);
      oe  = ($urandom_range(0, 3) == 0);
      lv  = 16'($urandom);
      off = 9'($urandom);
      drive(r, s, re, ce, le, oe, lv, off);
      modelStep(r, s, re, ce, le, oe, lv, off);
      checkAll($sformatf("rnd%0d", n), 16'(mPc), 4'(mStack.size()), mOv, mUn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
